// File: rtl/mod_exp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod_exp_pkg
// Purpose  : Shared types and constants for the modular exponentiation
//            sequencer (state/phase encodings, core size field width).
// Ports    : none (package)
// Config   : MOD_EXP_CONST_TIME_EN (used by mod_exp_ctrl, not here)
// Revision : 1.0 - initial release
// ============================================================================
package mod_exp_pkg;

  localparam int M_SIZE_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TO_MONT   = 3'd1,
    ST_SQR       = 3'd2,
    ST_MUL       = 3'd3,
    ST_FROM_MONT = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // Every core operation is a one-cycle ISSUE followed by a WAIT for the
  // core's completion pulse.
  typedef enum logic {
    PH_ISSUE = 1'b0,
    PH_WAIT  = 1'b1
  } phase_t;

endpackage
`default_nettype wire

// File: rtl/mod_exp_bit_iter.sv
`default_nettype none
// ============================================================================
// Module   : mod_exp_bit_iter
// Purpose  : Holds the captured exponent and walks it MSB-first.
// Ports    : clk, rst_n    - clock, async active-low reset
//            load, exp_in  - capture exponent, point at its MSB
//            step          - move to the next lower bit
//            cur_bit       - exponent bit at the current index
//            last_bit      - current index is bit 0
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module mod_exp_bit_iter #(
  parameter int EBITS = 2048
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [EBITS-1:0] exp_in,
  input  logic             step,
  output logic             cur_bit,
  output logic             last_bit
);

  localparam int IDX_W = (EBITS > 1) ? $clog2(EBITS) : 1;
  localparam logic [IDX_W-1:0] c_idx_top = IDX_W'(EBITS - 1);

  logic [EBITS-1:0] r_exp_q;
  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp_q <= '0;
      r_idx   <= '0;
    end else if (load) begin
      r_exp_q <= exp_in;
      r_idx   <= c_idx_top;
    end else if (step && (r_idx != '0)) begin
      r_idx <= r_idx - 1'b1;
    end
  end

  assign cur_bit  = r_exp_q[r_idx];
  assign last_bit = (r_idx == '0);

endmodule
`default_nettype wire

// File: rtl/mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mod_exp_ctrl
// Purpose  : Sequences y = base^exp mod m on one shared Montgomery multiplier
//            core: conversion into the Montgomery domain, MSB-first
//            square-and-multiply, conversion back out.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            enable_p                   - start pulse, samples operands
//            base, exp, m, r_red,
//            r2_red, m_size             - operands (r_red = R mod m,
//                                         r2_red = R^2 mod m)
//            y, done_irq_p, busy        - result, completion pulse, busy
//            mul_enable_p, mul_a, mul_b,
//            mul_m, mul_m_size          - core request (operands registered)
//            mul_y, mul_done_p          - core response
// Config   : MOD_EXP_CONST_TIME_EN - always run the multiply step, discarding
//            its result for zero exponent bits (exponent-independent timing).
// Revision : 1.0 - initial release
// ============================================================================
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int NBITS = 2048,
  parameter int EBITS = 2048
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_p,
  input  logic [NBITS-1:0]    base,
  input  logic [EBITS-1:0]    exp,
  input  logic [NBITS-1:0]    m,
  input  logic [NBITS-1:0]    r_red,
  input  logic [NBITS-1:0]    r2_red,
  input  logic [M_SIZE_W-1:0] m_size,
  output logic [NBITS-1:0]    y,
  output logic                done_irq_p,
  output logic                busy,
  output logic                mul_enable_p,
  output logic [NBITS-1:0]    mul_a,
  output logic [NBITS-1:0]    mul_b,
  output logic [NBITS-1:0]    mul_m,
  output logic [M_SIZE_W-1:0] mul_m_size,
  input  logic [NBITS-1:0]    mul_y,
  input  logic                mul_done_p
);

  state_t           r_state, w_state_nxt;
  phase_t           r_phase, w_phase_nxt;
  logic [NBITS-1:0] r_bm, w_bm_nxt;
  logic [NBITS-1:0] r_acc, w_acc_nxt;
  logic [NBITS-1:0] w_a_nxt, w_b_nxt;
  logic             w_load, w_step, w_advance, w_start_op, w_y_upd;
  logic             w_cur_bit, w_last_bit;
  logic             w_do_mul, w_keep_mul;

  mod_exp_bit_iter #(
    .EBITS (EBITS)
  ) u_bit_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .exp_in   (exp),
    .step     (w_step),
    .cur_bit  (w_cur_bit),
    .last_bit (w_last_bit)
  );

`ifdef MOD_EXP_CONST_TIME_EN
  // Multiply on every bit; zero bits throw the product away.
  assign w_do_mul   = 1'b1;
  assign w_keep_mul = w_cur_bit;
`else
  assign w_do_mul   = w_cur_bit;
  assign w_keep_mul = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_bm_nxt    = r_bm;
    w_acc_nxt   = r_acc;
    w_a_nxt     = mul_a;
    w_b_nxt     = mul_b;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_advance   = 1'b0;
    w_start_op  = 1'b0;
    w_y_upd     = 1'b0;

    // Completion pulses only count in WAIT; in ISSUE they are ignored.
    case (r_state)
      ST_IDLE: begin
        w_phase_nxt = PH_ISSUE;
        if (enable_p) begin
          w_load      = 1'b1;
          w_acc_nxt   = r_red;
          w_state_nxt = ST_TO_MONT;
          w_start_op  = 1'b1;
        end
      end
      ST_TO_MONT: begin
        if (r_phase == PH_ISSUE) begin
          w_phase_nxt = PH_WAIT;
        end else if (mul_done_p) begin
          w_bm_nxt    = mul_y;
          w_state_nxt = ST_SQR;
          w_start_op  = 1'b1;
        end
      end
      ST_SQR: begin
        if (r_phase == PH_ISSUE) begin
          w_phase_nxt = PH_WAIT;
        end else if (mul_done_p) begin
          w_acc_nxt  = mul_y;
          w_start_op = 1'b1;
          if (w_do_mul) w_state_nxt = ST_MUL;
          else          w_advance   = 1'b1;
        end
      end
      ST_MUL: begin
        if (r_phase == PH_ISSUE) begin
          w_phase_nxt = PH_WAIT;
        end else if (mul_done_p) begin
          if (w_keep_mul) w_acc_nxt = mul_y;
          w_start_op = 1'b1;
          w_advance  = 1'b1;
        end
      end
      ST_FROM_MONT: begin
        if (r_phase == PH_ISSUE) begin
          w_phase_nxt = PH_WAIT;
        end else if (mul_done_p) begin
          w_y_upd     = 1'b1;
          w_state_nxt = ST_DONE;
          w_phase_nxt = PH_ISSUE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = PH_ISSUE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = PH_ISSUE;
      end
    endcase

    if (w_advance) begin
      if (w_last_bit) begin
        w_state_nxt = ST_FROM_MONT;
      end else begin
        w_step      = 1'b1;
        w_state_nxt = ST_SQR;
      end
    end

    // Operands for the next ISSUE are chosen from the post-update acc/bm so
    // the new operation can start the cycle right after the previous done.
    if (w_start_op) begin
      w_phase_nxt = PH_ISSUE;
      case (w_state_nxt)
        ST_TO_MONT: begin
          w_a_nxt = base;
          w_b_nxt = r2_red;
        end
        ST_SQR: begin
          w_a_nxt = w_acc_nxt;
          w_b_nxt = w_acc_nxt;
        end
        ST_MUL: begin
          w_a_nxt = w_acc_nxt;
          w_b_nxt = w_bm_nxt;
        end
        ST_FROM_MONT: begin
          w_a_nxt = w_acc_nxt;
          w_b_nxt = NBITS'(1);
        end
        default: begin
          w_a_nxt = mul_a;
          w_b_nxt = mul_b;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_phase    <= PH_ISSUE;
      r_bm       <= '0;
      r_acc      <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_m      <= '0;
      mul_m_size <= '0;
      y          <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_bm    <= w_bm_nxt;
      r_acc   <= w_acc_nxt;
      mul_a   <= w_a_nxt;
      mul_b   <= w_b_nxt;
      if (w_load) begin
        mul_m      <= m;
        mul_m_size <= m_size;
      end
      if (w_y_upd) y <= mul_y;
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign done_irq_p   = (r_state == ST_DONE);
  assign mul_enable_p = (r_phase == PH_ISSUE) &&
                        ((r_state == ST_TO_MONT) || (r_state == ST_SQR) ||
                         (r_state == ST_MUL)     || (r_state == ST_FROM_MONT));

endmodule
`default_nettype wire
